// File: rtl/lzw_decoder_core.sv
// ---------------------------------------------------------------------------
// lzw_decoder_core
//   LZW decompressor. Takes fixed-width codes, rebuilds the string dictionary
//   on the fly and emits the reconstructed bytes in original order.
//
//   Ports
//     clk_i          clock, all state changes on the rising edge
//     rst_ni         synchronous active-low reset
//     code_i         next input code (CODE_W bits)
//     code_valid_i   code_i is valid
//     code_ready_o   block accepts code_i this cycle (only in S_IDLE)
//     byte_o         decoded byte
//     byte_valid_o   byte_o is valid; held with byte_o until accepted
//     byte_ready_i   downstream accepts byte_o this cycle
//     clear_i        dictionary restart, sampled only in S_IDLE
//     dict_full_o    dictionary has no free entries left
//     error_o        sticky: a code beyond the next free entry was received
//     busy_o         high whenever the block is not in S_IDLE
// ---------------------------------------------------------------------------
module lzw_decoder_core #(
    parameter int unsigned CODE_W     = 12,
    parameter int unsigned FIRST_FREE = 256,
    parameter int unsigned STACK_AW   = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    input  logic              clear_i,
    output logic              dict_full_o,
    output logic              error_o,
    output logic              busy_o
);

    localparam int unsigned NC_W       = CODE_W + 1;
    localparam int unsigned SP_W       = STACK_AW + 1;
    localparam int unsigned DICT_SIZE  = 1 << CODE_W;
    localparam int unsigned STACK_SIZE = 1 << STACK_AW;

    localparam logic [CODE_W-1:0] FIRST_FREE_C = CODE_W'(FIRST_FREE);
    localparam logic [CODE_W-1:0] MAX_LIT_C    = CODE_W'(255);
    localparam logic [NC_W-1:0]   NEXT_RST_C   = NC_W'(FIRST_FREE);
    localparam logic [NC_W-1:0]   DICT_END_C   = NC_W'(DICT_SIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    // Control / datapath registers
    logic [1:0]        state_q,      state_d;
    logic [NC_W-1:0]   next_code_q,  next_code_d;
    logic              first_q,      first_d;
    logic [CODE_W-1:0] old_code_q,   old_code_d;
    logic [7:0]        old_first_q,  old_first_d;
    logic [CODE_W-1:0] in_code_q,    in_code_d;
    logic [CODE_W-1:0] cur_q,        cur_d;
    logic [7:0]        new_first_q,  new_first_d;
    logic [SP_W-1:0]   sp_q,         sp_d;
    logic [7:0]        byte_q,       byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              code_ready_q, code_ready_d;
    logic              full_q,       full_d;
    logic              error_q,      error_d;
    logic              busy_q,       busy_d;

    // Dictionary: one write port, synchronous read
    logic [CODE_W-1:0] prefix_mem [DICT_SIZE];
    logic [7:0]        append_mem [DICT_SIZE];
    logic [CODE_W-1:0] rd_prefix_q;
    logic [7:0]        rd_append_q;
    logic [CODE_W-1:0] rd_addr;
    logic              dict_we;

    // Reversal stack: chain walk yields bytes last-to-first
    logic [7:0]        stack_mem [STACK_SIZE];
    logic              push_en;
    logic [7:0]        push_data;
    logic [7:0]        top_byte;

    logic              code_bad;
    logic              code_kwk;

    assign code_ready_o = code_ready_q;
    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign dict_full_o  = full_q;
    assign error_o      = error_q;
    assign busy_o       = busy_q;

    // Code classification against the current dictionary extent
    assign code_bad = ({1'b0, code_i} > next_code_q) || (first_q && (code_i > MAX_LIT_C));
    assign code_kwk = ({1'b0, code_i} == next_code_q);

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        next_code_d  = next_code_q;
        first_d      = first_q;
        old_code_d   = old_code_q;
        old_first_d  = old_first_q;
        in_code_d    = in_code_q;
        cur_d        = cur_q;
        new_first_d  = new_first_q;
        sp_d         = sp_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;
        full_d       = full_q;
        error_d      = error_q;
        rd_addr      = cur_q;
        dict_we      = 1'b0;
        push_en      = 1'b0;
        push_data    = 8'h00;
        top_byte     = stack_mem[STACK_AW'(sp_q - SP_W'(1))];

        case (state_q)
            S_IDLE: begin
                if (clear_i) begin
                    next_code_d = NEXT_RST_C;
                    first_d     = 1'b1;
                    error_d     = 1'b0;
                    full_d      = 1'b0;
                end else if (code_valid_i && code_ready_q) begin
                    in_code_d = code_i;
                    if (code_bad) begin
                        error_d = 1'b1;
                    end else if (code_kwk) begin
                        // Code not yet in the dictionary: string is old + first(old)
                        push_en   = 1'b1;
                        push_data = old_first_q;
                        sp_d      = sp_q + SP_W'(1);
                        cur_d     = old_code_q;
                        rd_addr   = old_code_q;
                        state_d   = S_WALK;
                    end else begin
                        cur_d   = code_i;
                        rd_addr = code_i;
                        state_d = S_WALK;
                    end
                end
            end

            S_WALK: begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                if (cur_q >= FIRST_FREE_C) begin
                    // Read data belongs to cur_q; address the next link now
                    push_data = rd_append_q;
                    cur_d     = rd_prefix_q;
                    rd_addr   = rd_prefix_q;
                end else begin
                    push_data   = cur_q[7:0];
                    new_first_d = cur_q[7:0];
                    state_d     = S_ADD;
                end
            end

            S_ADD: begin
                if (!first_q && !full_q) begin
                    dict_we     = 1'b1;
                    next_code_d = next_code_q + NC_W'(1);
                    full_d      = ((next_code_q + NC_W'(1)) == DICT_END_C);
                end
                old_code_d   = in_code_q;
                old_first_d  = new_first_q;
                first_d      = 1'b0;
                // Preload the first output byte so it is visible on entering S_EMIT
                byte_d       = top_byte;
                sp_d         = sp_q - SP_W'(1);
                byte_valid_d = 1'b1;
                state_d      = S_EMIT;
            end

            S_EMIT: begin
                if (byte_valid_q && byte_ready_i) begin
                    if (sp_q != '0) begin
                        byte_d = top_byte;
                        sp_d   = sp_q - SP_W'(1);
                    end else begin
                        byte_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        code_ready_d = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            next_code_q  <= NEXT_RST_C;
            first_q      <= 1'b1;
            old_code_q   <= '0;
            old_first_q  <= 8'h00;
            in_code_q    <= '0;
            cur_q        <= '0;
            new_first_q  <= 8'h00;
            sp_q         <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            code_ready_q <= 1'b1;
            full_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_code_q  <= next_code_d;
            first_q      <= first_d;
            old_code_q   <= old_code_d;
            old_first_q  <= old_first_d;
            in_code_q    <= in_code_d;
            cur_q        <= cur_d;
            new_first_q  <= new_first_d;
            sp_q         <= sp_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            code_ready_q <= code_ready_d;
            full_q       <= full_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    // Dictionary arrays: write the new entry, registered chain-link read
    always_ff @(posedge clk_i) begin
        if (dict_we) begin
            prefix_mem[next_code_q[CODE_W-1:0]] <= old_code_q;
            append_mem[next_code_q[CODE_W-1:0]] <= new_first_q;
        end
        rd_prefix_q <= prefix_mem[rd_addr];
        rd_append_q <= append_mem[rd_addr];
    end

    // Reversal stack write port
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            stack_mem[sp_q[STACK_AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_lzw_decoder_core.sv
module tb_lzw_decoder_core;

    localparam int unsigned CW  = 9;
    localparam int unsigned FF  = 256;
    localparam int unsigned SAW = 9;
    localparam int DSZ = 1 << CW;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          code_ready;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          clear;
    logic          dict_full;
    logic          err;
    logic          busy;

    lzw_decoder_core #(.CODE_W(CW), .FIRST_FREE(FF), .STACK_AW(SAW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .code_i       (code),
        .code_valid_i (code_valid),
        .code_ready_o (code_ready),
        .byte_o       (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .clear_i      (clear),
        .dict_full_o  (dict_full),
        .error_o      (err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // ---------------- behavioural model: strings stored whole ----------------
    int            m_next;
    bit            m_first, m_err, m_full;
    int            m_old;
    byte unsigned  pool[$];
    int            e_off[DSZ];
    int            e_len[DSZ];
    byte unsigned  exp_q[$];
    byte unsigned  log_q[$];
    byte unsigned  s_tmp[$];

    task automatic model_reset();
        m_next = FF; m_first = 1'b1; m_err = 1'b0; m_full = 1'b0; m_old = 0;
    endtask

    task automatic get_str(input int c);
        s_tmp.delete();
        if (c < 256) s_tmp.push_back(8'(c));
        else for (int i = 0; i < e_len[c]; i++) s_tmp.push_back(pool[e_off[c] + i]);
    endtask

    task automatic model_code(input int c);
        byte unsigned s[$];
        if (c > m_next || (m_first && c > 255)) begin
            m_err = 1'b1;
            return;
        end
        if (c == m_next) begin
            get_str(m_old); s = s_tmp; s.push_back(s[0]);
        end else begin
            get_str(c); s = s_tmp;
        end
        if (!m_first && m_next < DSZ) begin
            get_str(m_old);
            e_off[m_next] = pool.size();
            e_len[m_next] = s_tmp.size() + 1;
            foreach (s_tmp[i]) pool.push_back(s_tmp[i]);
            pool.push_back(s[0]);
            m_next++;
            if (m_next == DSZ) m_full = 1'b1;
        end
        m_old = c;
        m_first = 1'b0;
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    // ---------------- downstream ready pattern ----------------
    int rdy_mode = 0;
    initial begin
        byte_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = !byte_ready;
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- output compare process ----------------
    logic       held = 1'b0;
    logic [7:0] held_byte = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid_hold", int'(byte_valid), 1);
                    chk("stall_byte_hold", int'(byte_out), int'(held_byte));
                end
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("[TB] FAIL spurious_byte: got %0d, expected no byte", byte_out);
                    end else begin
                        chk("byte", int'(byte_out), int'(exp_q.pop_front()));
                    end
                    log_q.push_back(byte_out);
                end
                held = byte_valid && !byte_ready;
                held_byte = byte_out;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_code(input int c);
        bit ok = 1'b0;
        @(posedge clk); #1;
        code = CW'(c);
        code_valid = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (code_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL accept_timeout: code %0d not accepted, expected acceptance", c);
            code_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        code_valid = 1'b0;
        model_code(c);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !byte_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL drain_timeout: %0d bytes pending, expected 0", exp_q.size());
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        model_reset();
        @(negedge clk);
        chk("clear_error", int'(err), 0);
        chk("clear_full", int'(dict_full), 0);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_error"}, int'(err), int'(m_err));
        chk({tag, "_full"}, int'(dict_full), int'(m_full));
    endtask

    task automatic chk_log(input string tag, input string lit);
        chk({tag, "_len"}, log_q.size(), lit.len());
        for (int i = 0; i < lit.len() && i < log_q.size(); i++)
            chk({tag, "_char"}, int'(log_q[i]), int'(lit[i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c, r, hi;
        bit ok;
        rst_n = 1'b0; code = '0; code_valid = 1'b0; clear = 1'b0;
        model_reset();

        // T1 reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_code_ready", int'(code_ready), 1);
        chk("rst_error", int'(err), 0);
        chk("rst_full", int'(dict_full), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // T2 basic
        log_q.delete();
        send_code(65); send_code(66); send_code(256); send_code(258);
        wait_drain();
        chk_log("t2", "ABABABA");
        chk("t2_model_next", m_next, 259);
        chk("t2_model_len258", e_len[258], 3);
        chk_flags("t2");

        // T3 KwKwK
        do_clear();
        log_q.delete();
        send_code(65); send_code(256);
        wait_drain();
        chk_log("t3", "AAA");
        chk("t3_model_next", m_next, 257);

        // T4 backpressure
        do_clear();
        rdy_mode = 1;
        log_q.delete();
        send_code(65); send_code(66); send_code(256); send_code(258);
        wait_drain();
        chk_log("t4", "ABABABA");
        rdy_mode = 0;

        // T5 error
        do_clear();
        log_q.delete();
        send_code(300);
        wait_drain();
        chk("t5_error_set", int'(err), 1);
        chk("t5_no_bytes", log_q.size(), 0);
        send_code(66);
        wait_drain();
        chk_log("t5", "B");
        chk("t5_error_sticky", int'(err), 1);
        do_clear();

        // T6 random fill to full dictionary, then beyond
        rdy_mode = 2;
        for (int n = 0; n < 320; n++) begin
            r = $urandom_range(0, 99);
            if (m_first) c = $urandom_range(0, 255);
            else if (r == 0 && m_next < DSZ - 1) c = $urandom_range(m_next + 1, DSZ - 1);
            else if (r < 20 && m_next < DSZ) c = m_next;
            else if (r < 50 || m_next == FF) c = $urandom_range(0, 255);
            else begin
                hi = (m_next < DSZ) ? m_next - 1 : DSZ - 1;
                c = $urandom_range(FF, hi);
            end
            send_code(c);
            wait_drain();
            chk_flags("t6");
        end
        chk("t6_full_reached", int'(dict_full), 1);
        chk("t6_model_next", m_next, DSZ);

        // Reset in the middle of emitting a long string
        rdy_mode = 0;
        send_code(DSZ - 1);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (byte_valid) begin ok = 1'b1; break; end
        end
        chk("t6_emit_started", int'(ok), 1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_byte_valid", int'(byte_valid), 0);
        chk("t6_rst_code_ready", int'(code_ready), 1);
        chk("t6_rst_full", int'(dict_full), 0);
        exp_q.delete();
        model_reset();
        #1 rst_n = 1'b1;
        log_q.delete();
        send_code(67);
        wait_drain();
        chk_log("t6_after_rst", "C");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
